imem_port_arbiter: RTL

- Shares the single port of the 14-bit-word-addressed instruction ROM between two requesters: the CPU fetch path and the UART program loader.
- Sequences ownership with a handshake. It stalls the fetch unit while the loader owns the port and issues a PC restart when loading ends.
- Sits between the fetch unit's ROM address/instruction interface, the UART loader, and the block RAM.

---
 rtl/imem_port_arbiter_pkg.sv | 16 +
 rtl/imem_load_watchdog.sv | 40 ++++
 rtl/imem_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-ROM port arbiter, the fetch unit and the UART loader.
package imem_port_arbiter_pkg;

  localparam int unsigned IMEM_ADDR_W   = 14;
  localparam int unsigned IMEM_DEPTH    = 16384;
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;
  localparam int unsigned IMEM_TIMEOUT  = 1000000;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/imem_load_watchdog.sv
// Idle-cycle watchdog for a loader that holds the ROM port without writing.
// Only instantiated when IMEM_LOAD_TIMEOUT_EN is defined.
module imem_load_watchdog
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = IMEM_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic active_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int unsigned   CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || kick_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th consecutive idle cycle so the next state is RELEASE.
  assign expire_o = active_i && !kick_i && (cnt_q == LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the instruction-ROM port between CPU fetch and the UART program loader.
// Define IMEM_LOAD_TIMEOUT_EN to build in the idle-load watchdog.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned DEPTH    = IMEM_DEPTH,
  parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD,
  parameter int unsigned TIMEOUT  = IMEM_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_adr_i,
  output logic [31:0]       fetch_instr_o,
  output logic              cpu_stall_o,
  output logic              cpu_restart_o,
  input  logic              load_req_i,
  output logic              load_grant_o,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_adr_i,
  input  logic [31:0]       load_data_i,
  input  logic              load_done_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [ADDR_W:0]   load_count_o,
  output logic              load_err_o
);

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  arb_state_e      state_q, state_d, st;
  logic [ADDR_W:0] count_q, count_d;
  logic            err_q, err_d;
  logic            accept, oor, wd_expire;

`ifdef IMEM_LOAD_TIMEOUT_EN
  imem_load_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .active_i (state_q == ST_LOAD),
    .kick_i   (load_we_i),
    .expire_o (wd_expire)
  );
`else
  // TIMEOUT only matters when the watchdog is built in.
  assign wd_expire = (TIMEOUT == 0) && 1'b0;
`endif

  assign mem_en_o = 1'b1;

  // Reset is synchronous, yet outputs decode it combinationally so a write in
  // the reset cycle is suppressed and grant drops at once.
  always_comb begin
    st            = reset ? ST_RUN : state_q;
    state_d       = state_q;
    cpu_stall_o   = 1'b0;
    cpu_restart_o = 1'b0;
    load_grant_o  = 1'b0;
    mem_we_o      = 1'b0;
    mem_adr_o     = fetch_adr_i;
    mem_wdata_o   = '0;
    fetch_instr_o = mem_rdata_i;
    accept        = 1'b0;
    oor           = 1'b0;
    unique case (st)
      ST_RUN: begin
        cpu_stall_o = load_req_i && !reset;
        if (load_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        cpu_stall_o   = 1'b1;
        fetch_instr_o = NOP_WORD;
        state_d       = load_req_i ? ST_LOAD : ST_RUN;
      end
      ST_LOAD: begin
        load_grant_o  = 1'b1;
        cpu_stall_o   = 1'b1;
        fetch_instr_o = NOP_WORD;
        mem_adr_o     = load_adr_i;
        mem_wdata_o   = load_data_i;
        if (load_we_i) begin
          accept = ({1'b0, load_adr_i} < DEPTH_L);
          oor    = !accept;
        end
        mem_we_o = accept;
        if (load_done_i || !load_req_i || wd_expire) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        cpu_stall_o   = 1'b1;
        cpu_restart_o = 1'b1;
        fetch_instr_o = NOP_WORD;
        mem_adr_o     = '0;
        state_d       = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    count_d = count_q;
    err_d   = err_q | oor | wd_expire;
    if (state_q == ST_DRAIN && load_req_i) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept && count_q != COUNT_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign load_count_o = count_q;
  assign load_err_o   = err_q;

endmodule
